inst_fetch_queue: RTL

- Fetch stage directly downstream of the PC register. Consumes the PC stream (pc/ce) and issues in-order requests to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned instructions, tagged with their PC, in a DEPTH-entry FIFO and presents them to decode with valid/ready.
- Provides backpressure to the PC stage (pc_stall_o) and a flush that discards buffered and in-flight fetches.

---
 rtl/inst_fetch_queue_if.sv | 49 ++++
 rtl/inst_fetch_queue.sv | 139 +++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bus bundle: PC stream, instruction memory port and decode port.
// The DUT takes the slave view; the environment driving it takes master.
interface inst_fetch_queue_if;
    logic [31:0] pc_i;
    logic        pc_ce_i;
    logic        pc_stall_o;
    logic        flush_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        id_valid_o;
    logic [31:0] id_inst_o;
    logic [31:0] id_pc_o;
    logic        id_ready_i;

    modport slave (
        input  pc_i,
        input  pc_ce_i,
        output pc_stall_o,
        input  flush_i,
        output imem_req_o,
        output imem_addr_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i,
        output id_valid_o,
        output id_inst_o,
        output id_pc_o,
        input  id_ready_i
    );

    modport master (
        output pc_i,
        output pc_ce_i,
        input  pc_stall_o,
        output flush_i,
        input  imem_req_o,
        input  imem_addr_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i,
        input  id_valid_o,
        input  id_inst_o,
        input  id_pc_o,
        output id_ready_i
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: issues in-order imem requests for accepted PCs
// and buffers PC-tagged instructions for decode (first-word-fall-through).
module inst_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input logic               clk,
    input logic               reset_n,
    inst_fetch_queue_if.slave bus
);
    localparam int CW = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CW-1:0]    cnt_t;
    typedef logic [CW:0]      sum_t;

    localparam sum_t DEPTH_S = sum_t'(DEPTH);

    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    cnt_t        outst_q, outst_d;
    cnt_t        drop_q, drop_d;
    cnt_t        count_q, count_d;
    ptr_t        rd_q, rd_d;
    ptr_t        wr_q, wr_d;
    ptr_t        tw_q, tw_d;
    ptr_t        tr_q, tr_d;

    logic [31:0] pc_mem_q   [DEPTH];
    logic [31:0] inst_mem_q [DEPTH];
    logic [31:0] tag_q      [DEPTH];

    logic grant;
    logic resp;
    logic drop;
    logic push;
    logic pop;
    logic credit_full;
    logic stall;
    logic accept;
    sum_t used;

    // Credits cover buffered, in-flight and pending fetches, so a
    // response always has a free slot and the tag FIFO never overflows.
    assign used = sum_t'(count_q) + sum_t'(outst_q) + sum_t'(req_q);
    assign credit_full = (used >= DEPTH_S);

    assign grant  = req_q & bus.imem_gnt_i;
    assign resp   = bus.imem_rvalid_i & (outst_q != '0);
    assign drop   = resp & (drop_q != '0);
    assign push   = resp & ~drop & ~bus.flush_i;
    assign pop    = (count_q != '0) & bus.id_ready_i & ~bus.flush_i;
    assign stall  = bus.flush_i | (req_q & ~bus.imem_gnt_i) | credit_full;
    assign accept = bus.pc_ce_i & ~stall;

    always_comb begin
        req_d   = req_q;
        addr_d  = addr_q;
        drop_d  = drop_q;
        count_d = count_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        outst_d = outst_q + cnt_t'(grant) - cnt_t'(resp);
        tw_d    = tw_q + ptr_t'(grant);
        tr_d    = tr_q + ptr_t'(resp);

        if (accept) begin
            req_d  = 1'b1;
            addr_d = bus.pc_i;
        end else if (grant) begin
            req_d = 1'b0;
        end

        // Everything still in flight after this cycle is discarded on return;
        // the tag FIFO drains in step with those drops.
        if (bus.flush_i) begin
            req_d   = 1'b0;
            count_d = '0;
            rd_d    = '0;
            wr_d    = '0;
            drop_d  = outst_d;
        end else begin
            drop_d  = drop_q - cnt_t'(drop);
            wr_d    = wr_q + ptr_t'(push);
            rd_d    = rd_q + ptr_t'(pop);
            count_d = count_q + cnt_t'(push) - cnt_t'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            req_q   <= 1'b0;
            addr_q  <= '0;
            outst_q <= '0;
            drop_q  <= '0;
            count_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            tw_q    <= '0;
            tr_q    <= '0;
        end else begin
            req_q   <= req_d;
            addr_q  <= addr_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
            count_q <= count_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            tw_q    <= tw_d;
            tr_q    <= tr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
                tag_q[i]      <= '0;
            end
        end else begin
            if (grant) begin
                tag_q[tw_q] <= addr_q;
            end
            if (push) begin
                pc_mem_q[wr_q]   <= tag_q[tr_q];
                inst_mem_q[wr_q] <= bus.imem_rdata_i;
            end
        end
    end

    assign bus.imem_req_o  = req_q;
    assign bus.imem_addr_o = addr_q;
    assign bus.pc_stall_o  = stall;
    assign bus.id_valid_o  = (count_q != '0);
    assign bus.id_inst_o   = inst_mem_q[rd_q];
    assign bus.id_pc_o     = pc_mem_q[rd_q];

endmodule
